// File: rtl/fxp_add_pipe.sv
// Pipelined signed fixed-point add/sub with saturate or wrap on overflow; latency LAT cycles, 1 sample/cycle.
// Backpressure: empty stages still load under stall, so in_ready drops only with all LAT stages full and out_ready low.
module fxp_add_pipe #(
   parameter int W   = 19,
   parameter int SAT = 1,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] data1,
   input  logic [W-1:0] data2,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         ovf,
   output logic         ovf_sticky,
   input  logic         ovf_clr
);

   typedef struct packed {
      logic         ovf;
      logic [W-1:0] res;
   } stage_t;

   logic [W:0]     a_ext;
   logic [W:0]     b_ext;
   logic [W:0]     sum;
   logic           sum_ovf;
   stage_t         calc;

   logic [LAT-1:0] vld;
   logic [LAT-1:0] ld;
   logic [LAT-1:0] src_vld;
   stage_t         dat     [LAT];
   stage_t         src_dat [LAT];

   // Operands widened by one bit so that negating the most negative value is exact.
   always_comb begin
      a_ext    = {data1[W-1], data1};
      b_ext    = {data2[W-1], data2};
      sum      = sub ? (a_ext - b_ext) : (a_ext + b_ext);
      sum_ovf  = sum[W] ^ sum[W-1];
      calc.ovf = sum_ovf;
      calc.res = sum[W-1:0];
      if ((SAT != 0) && sum_ovf) begin
         calc.res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

   // A stage may load unless it and every stage after it is full while the output stalls.
   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         ld[k] = out_ready;
         for (int j = k; j < LAT; j++) begin
            if (!vld[j]) ld[k] = 1'b1;
         end
      end
      src_vld[0] = in_valid;
      src_dat[0] = calc;
      for (int k = 1; k < LAT; k++) begin
         src_vld[k] = vld[k-1];
         src_dat[k] = dat[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int k = 0; k < LAT; k++) dat[k] <= '0;
      end else begin
         for (int k = 0; k < LAT; k++) begin
            if (ld[k]) begin
               vld[k] <= src_vld[k];
               if (src_vld[k]) dat[k] <= src_dat[k];
            end
         end
      end
   end

   // Set has priority over clear; only transferred results count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = vld[LAT-1];
   assign result    = dat[LAT-1].res;
   assign ovf       = dat[LAT-1].ovf;

endmodule

// File: tb/tb_fxp_add_pipe.sv
// Bench for fxp_add_pipe: four instances (saturate/wrap, LAT 1/2/4) share stimulus; a queue scoreboard
// per instance predicts results, in_ready and the sticky flag from plain integer arithmetic.
module tb_fxp_add_pipe;

   localparam int W  = 19;
   localparam int ND = 4;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 2;
         1:       return 2;
         2:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int sat_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          sub       = 1'b0;
   logic          out_ready = 1'b1;
   logic          ovf_clr   = 1'b0;
   logic [W-1:0]  data1     = '0;
   logic [W-1:0]  data2     = '0;
   logic [ND-1:0] in_ready_v;
   logic [ND-1:0] out_valid_v;
   logic [ND-1:0] ovf_v;
   logic [ND-1:0] stk_v;
   logic [W-1:0]  res_v [ND];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      fxp_add_pipe #(.W(W), .SAT(sat_of(gi)), .LAT(lat_of(gi))) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready_v[gi]),
         .data1      (data1),
         .data2      (data2),
         .sub        (sub),
         .out_valid  (out_valid_v[gi]),
         .out_ready  (out_ready),
         .result     (res_v[gi]),
         .ovf        (ovf_v[gi]),
         .ovf_sticky (stk_v[gi]),
         .ovf_clr    (ovf_clr)
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      longint r;
      bit     o;
   } exp_t;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input int sat);
      exp_t   e;
      longint av, bv, sm, md, mx;
      av  = longint'($signed(a));
      bv  = longint'($signed(b));
      sm  = s ? (av - bv) : (av + bv);
      md  = longint'(1) << W;
      mx  = md / 2 - 1;
      e.o = (sm > mx) || (sm < -(md / 2));
      if (e.o && sat != 0) begin
         e.r = (sm > mx) ? mx : -(md / 2);
      end else begin
         e.r = ((sm % md) + md) % md;
         if (e.r > mx) e.r -= md;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0:       return {1'b0, {(W-1){1'b1}}};
         1:       return {1'b1, {(W-1){1'b0}}};
         2:       return '0;
         3:       return {W{1'b1}};
         default: return r[W-1:0];
      endcase
   endfunction

   exp_t q [ND][$];
   bit   stk_m [ND];
   bit   mon_nxt;
   exp_t mon_e;

   // Scoreboard: occupancy is the number of accepted-but-unemitted samples.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ND; i++) begin
            q[i].delete();
            stk_m[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < ND; i++) begin
            chk($sformatf("sticky[%0d]", i), stk_v[i], stk_m[i]);
            chk($sformatf("in_ready[%0d]", i), in_ready_v[i],
                (out_ready || q[i].size() < lat_of(i)) ? 1 : 0);
            mon_nxt = ovf_clr ? 1'b0 : stk_m[i];
            if (out_valid_v[i]) begin
               if (q[i].size() == 0) begin
                  chk($sformatf("spurious_out[%0d]", i), out_valid_v[i], 0);
               end else begin
                  mon_e = q[i][0];
                  chk($sformatf("res[%0d]", i), longint'($signed(res_v[i])), mon_e.r);
                  chk($sformatf("ovf[%0d]", i), ovf_v[i], mon_e.o);
                  if (out_ready) begin
                     void'(q[i].pop_front());
                     if (mon_e.o) mon_nxt = 1'b1;
                  end
               end
            end
            if (in_valid && in_ready_v[i]) q[i].push_back(model(data1, data2, sub, sat_of(i)));
            stk_m[i] = mon_nxt;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [ND-1:0] got, input logic [ND-1:0] exp);
      for (int i = 0; i < ND; i++) chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
   endtask

   int va [7] = '{100000, 200000, 262143, -200000, 0, -1, 5};
   int vb [7] = '{50000, 100000, 0, -100000, -262144, 262143, 7};
   bit vs [7] = '{0, 0, 0, 0, 1, 1, 1};
   int es [7] = '{150000, 262143, 262143, -262144, 262143, -262144, -2};
   int ew [7] = '{150000, -224288, 262143, 224288, -262144, -262144, -2};
   bit eo [7] = '{0, 1, 0, 1, 1, 0, 0};

   int           lat_seen [ND];
   int           hi_cnt   [ND];
   logic [W-1:0] bpa [6];
   logic [W-1:0] bpb [6];
   int           k, stall;
   bit           started, saw_block;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) step();
      for (int i = 0; i < ND; i++) chk($sformatf("rst_res[%0d]", i), longint'(res_v[i]), 0);
      chk_all("rst_out_valid", out_valid_v, '0);
      chk_all("rst_ovf", ovf_v, '0);
      chk_all("rst_sticky", stk_v, '0);
      rst_n = 1'b1;
      #1;
      chk_all("rst_in_ready", in_ready_v, '1);
      step();

      // Directed vectors, one at a time, out_ready held high
      for (int v = 0; v < 7; v++) begin
         in_valid = 1'b1;
         data1    = va[v][W-1:0];
         data2    = vb[v][W-1:0];
         sub      = vs[v];
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         for (int i = 0; i < ND; i++) begin
            lat_seen[i] = 0;
            hi_cnt[i]   = 0;
         end
         for (int cyc = 1; cyc <= 12; cyc++) begin
            for (int i = 0; i < ND; i++) begin
               if (out_valid_v[i]) begin
                  hi_cnt[i]++;
                  if (lat_seen[i] == 0) begin
                     lat_seen[i] = cyc;
                     chk($sformatf("vec%0d_res[%0d]", v, i), longint'($signed(res_v[i])),
                         longint'((sat_of(i) != 0) ? es[v] : ew[v]));
                     chk($sformatf("vec%0d_ovf[%0d]", v, i), ovf_v[i], eo[v]);
                  end
               end
            end
            step();
         end
         for (int i = 0; i < ND; i++) begin
            chk($sformatf("vec%0d_latency[%0d]", v, i), lat_seen[i], lat_of(i));
            chk($sformatf("vec%0d_valid_cycles[%0d]", v, i), hi_cnt[i], 1);
         end
      end

      // Sticky flag
      chk_all("stk_after_vectors", stk_v, '1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk_all("stk_clr_alone", stk_v, '0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data1     = 19'd200000;
      data2     = 19'd100000;
      sub       = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      chk_all("stk_stall_valid", out_valid_v, '1);
      chk_all("stk_stall_ovf", ovf_v, '1);
      chk_all("stk_stall_sticky", stk_v, '0);
      out_ready = 1'b1;
      ovf_clr   = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk_all("stk_set_wins", stk_v, '1);
      chk_all("stk_drained", out_valid_v, '0);

      // Backpressure: six samples, each held until instance 0 takes it
      for (int j = 0; j < 6; j++) begin
         bpa[j] = rnd_op();
         bpb[j] = rnd_op();
      end
      k = 0; stall = 0; started = 0; saw_block = 0;
      for (int c = 0; c < 40; c++) begin
         if (k < 6) begin
            in_valid = 1'b1;
            data1    = bpa[k];
            data2    = bpb[k];
            sub      = k[0];
         end else begin
            in_valid = 1'b0;
         end
         if (!started && out_valid_v[0]) begin
            started = 1;
            stall   = 5;
         end
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         @(negedge clk);
         if (!in_ready_v[0]) saw_block = 1;
         if (in_valid && in_ready_v[0]) k++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_items_accepted", k, 6);
      chk("bp_in_ready_dropped", saw_block, 1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         data1     = rnd_op();
         data2     = rnd_op();
         sub       = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 9) < 6);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;
      repeat (10) step();
      for (int i = 0; i < ND; i++) chk($sformatf("drain_empty[%0d]", i), q[i].size(), 0);

      // Reset with samples in flight
      in_valid = 1'b1;
      data1    = 19'd200000;
      data2    = 19'd100000;
      sub      = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      chk_all("pre_rst_sticky", stk_v, '1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data1     = 19'd1234;
      data2     = 19'd4321;
      repeat (2) step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst_valid", out_valid_v, '0);
      chk_all("async_rst_sticky", stk_v, '0);
      repeat (2) step();
      rst_n = 1'b1;
      #1;
      chk_all("post_rst_in_ready", in_ready_v, '1);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         chk_all($sformatf("post_rst_no_out%0d", c), out_valid_v, '0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fxp_add_pipe.md
Name: fxp_add_pipe

Overview:
- Parametrised, pipelined signed fixed-point adder/subtractor.
- Successor to the team's 19-bit combinational signed adder. Adds:
  - configurable width and latency;
  - saturate or wrap mode on overflow;
  - per-sample add/subtract select;
  - valid/ready flow control with backpressure;
  - per-result and sticky overflow flags.
- Sits in the datapath between fixed-point producer and consumer stages.

Parameters:
- W, 19, data width in bits, two's complement (W >= 4).
- SAT, 1, overflow mode: 1 = saturate to the range limit, 0 = wrap (keep the low W bits).
- LAT, 2, number of pipeline register stages (1..4); also the latency in cycles.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept an input this cycle.
- data1  input  W  signed operand A.
- data2  input  W  signed operand B.
- sub  input  1  0: A+B; 1: A-B. Sampled with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  W  signed result.
- ovf  output  1  overflow occurred for the current result; qualified by out_valid.
- ovf_sticky  output  1  latched overflow indication.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: all stage valid bits, result, ovf and ovf_sticky clear to 0 immediately on rst_n low. in_ready = 1 after reset.
- Reset mid-operation: all in-flight samples are discarded. Nothing is emitted after release.
- Arithmetic:
  - Sign-extend both operands to W+1 bits.
  - Form s = A + B, or s = A - B (negation computed at W+1 bits, so B = -2^(W-1) is exact).
  - Overflow when s[W] != s[W-1].
  - SAT=1 with overflow: result = 2^(W-1)-1 if s[W]=0, else -2^(W-1).
  - SAT=0, or no overflow: result = s[W-1:0].
  - ovf travels with its sample in both modes.
- Computation placement: arithmetic is done before stage-1 registration. Remaining stages are pure delay.
- Handshake:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - Stage k loads when it is empty or when it is emptying this cycle (downstream stage accepts).
  - in_ready = stage 1 can load. Combinational from out_ready through the stage valid chain; no input-to-output combinational path on data.
  - in_valid is not required to wait for in_ready.
- Latency and throughput:
  - With out_ready held at 1, out_valid rises exactly LAT cycles after the input transfer.
  - Throughput is 1 sample per cycle.
  - Order is preserved; no drop or duplication.
- Stall: while out_valid & ~out_ready, result and ovf are held stable.
  - A full pipeline holds exactly LAT samples.
  - in_ready = 0 only when all stages are full and out_ready = 0.
- Sticky flag:
  - ovf_sticky sets on an output transfer with ovf=1.
  - ovf_clr clears it on the next edge.
  - Set and clear in the same cycle: set wins.
  - ovf_sticky is unaffected by stalled (untransferred) overflows.
- Empty pipeline: out_valid = 0. result/ovf retain their last values and are don't-care for checking.

Test Plan:
- Basic, W=19, LAT=2, out_ready=1: 100000 + 50000, sub=0 → result 150000, ovf=0, out_valid high exactly 2 cycles after the input transfer, for 1 cycle.
- Positive overflow: 200000 + 100000 → SAT=1: 262143, ovf=1; SAT=0: -224288, ovf=1. Also 262143 + 0 → 262143, ovf=0.
- Negative / subtract boundaries, SAT=1:
  - -200000 + -100000 → -262144, ovf=1.
  - 0 - (-262144) → 262143, ovf=1.
  - -1 - 262143 → -262144, ovf=0.
- Backpressure: stream 6 back-to-back samples; hold out_ready=0 for 5 cycles starting at the first out_valid → in_ready drops once 2 samples are held. All 6 results appear in order, no loss or duplication, result stable while stalled. Repeat with LAT=1 and LAT=4.
- Sticky flag:
  - Overflow transfer → ovf_sticky=1.
  - ovf_clr alone → 0 next cycle.
  - ovf_clr in the same cycle as an overflow transfer → stays 1.
  - Overflowing sample stalled with out_ready=0 → sticky stays 0 until transferred.
- Reset mid-stream: rst_n low with 2 samples in flight → out_valid and ovf_sticky 0 immediately (asynchronous), no stale output after release, in_ready=1 on the first cycle out of reset.
